// File: rtl/packet_fifo_if.sv
// Handshake bundle for packet_fifo: write port, read port and status.
// drop_count exists only when PACKET_FIFO_STATS_EN is defined.
interface packet_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 12
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_enable;
  logic                  data_in_start;
  logic                  data_in_end;
  logic                  data_in_abort;
  logic                  full;
  logic [FIFO_DEPTH:0]   count;
  logic [FIFO_DEPTH:0]   frame_count;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_start;
  logic                  data_out_end;
  logic                  data_out_valid;
  logic                  data_out_enable;
  logic                  data_out_rewind;
`ifdef PACKET_FIFO_STATS_EN
  logic [15:0]           drop_count;
`endif

  modport master (
    output data_in, data_in_enable, data_in_start, data_in_end, data_in_abort,
           data_out_enable, data_out_rewind,
    input  full, count, frame_count, data_out, data_out_start, data_out_end, data_out_valid
`ifdef PACKET_FIFO_STATS_EN
           , drop_count
`endif
  );

  modport slave (
    input  data_in, data_in_enable, data_in_start, data_in_end, data_in_abort,
           data_out_enable, data_out_rewind,
    output full, count, frame_count, data_out, data_out_start, data_out_end, data_out_valid
`ifdef PACKET_FIFO_STATS_EN
           , drop_count
`endif
  );
endinterface

// File: rtl/packet_fifo.sv
// Single-clock frame-aware FIFO: commit on end word, atomic discard, read-side rewind.
// Define PACKET_FIFO_STATS_EN to add the saturating drop_count output.
module packet_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 12
) (
  input logic          reset,
  input logic          data_in_clock,
  packet_fifo_if.slave fifo
);
  localparam logic [1:0] IDLE = 2'd0, IN_FRAME = 2'd1, DROP = 2'd2;

  typedef logic [FIFO_DEPTH:0] ptr_t;
  localparam ptr_t ONE  = ptr_t'(1);
  localparam ptr_t FULL = ptr_t'(1) << FIFO_DEPTH;

  typedef struct packed {
    logic                  sof;
    logic                  eof;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t mem [1<<FIFO_DEPTH];

  ptr_t wr_ptr, commit_ptr, rd_ptr, release_ptr, frame_start_ptr;
  ptr_t wr_nxt, commit_nxt, rd_nxt, release_nxt;
  ptr_t word_cnt, frame_cnt;
  logic [1:0] state, state_nxt;
  logic [FIFO_DEPTH-1:0] waddr;
  logic we, commit, rel, rew, pop, used_full, out_open, head_vld, full_q;
  entry_t head;

  // Outside IN_FRAME wr_ptr == commit_ptr, so this is also "committed data fills the buffer".
  assign used_full = (wr_ptr - release_ptr) == FULL;

  always_comb begin
    state_nxt  = state;
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    we         = 1'b0;
    commit     = 1'b0;
    waddr      = wr_ptr[FIFO_DEPTH-1:0];
    if (fifo.data_in_abort) begin
      wr_nxt    = commit_ptr;
      state_nxt = IDLE;
    end else if (fifo.data_in_enable) begin
      if (fifo.data_in_start) begin
        if (state != IN_FRAME && used_full) begin
          state_nxt = fifo.data_in_end ? IDLE : DROP;
        end else begin
          // a start always (re)opens the frame at the committed boundary
          we        = 1'b1;
          waddr     = commit_ptr[FIFO_DEPTH-1:0];
          wr_nxt    = commit_ptr + ONE;
          commit    = fifo.data_in_end;
          state_nxt = fifo.data_in_end ? IDLE : IN_FRAME;
        end
      end else if (state == IN_FRAME) begin
        if (used_full) begin
          wr_nxt    = commit_ptr;
          state_nxt = DROP;
        end else begin
          we     = 1'b1;
          wr_nxt = wr_ptr + ONE;
          commit = fifo.data_in_end;
          if (fifo.data_in_end) state_nxt = IDLE;
        end
      end else if (state == DROP && fifo.data_in_end) begin
        state_nxt = IDLE;
      end
    end
    if (commit) commit_nxt = wr_nxt;
  end

  always_comb begin
    rew         = fifo.data_out_rewind & out_open;
    pop         = fifo.data_out_enable & head_vld & ~rew;
    rel         = pop & head.eof;
    rd_nxt      = rew ? frame_start_ptr : (pop ? rd_ptr + ONE : rd_ptr);
    release_nxt = rel ? rd_ptr + ONE : release_ptr;
  end

  always_ff @(posedge data_in_clock)
    if (we) mem[waddr] <= '{sof: fifo.data_in_start, eof: fifo.data_in_end, data: fifo.data_in};

  always_ff @(posedge data_in_clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      rd_ptr          <= '0;
      release_ptr     <= '0;
      frame_start_ptr <= '0;
      out_open        <= 1'b0;
      frame_cnt       <= '0;
      word_cnt        <= '0;
      full_q          <= 1'b0;
      head_vld        <= 1'b0;
      head            <= '0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_nxt;
      commit_ptr  <= commit_nxt;
      rd_ptr      <= rd_nxt;
      release_ptr <= release_nxt;
      if (pop && head.sof) frame_start_ptr <= rd_ptr;
      if (pop && head.eof)      out_open <= 1'b0;
      else if (pop && head.sof) out_open <= 1'b1;
      if (commit && !rel)      frame_cnt <= frame_cnt + ONE;
      else if (!commit && rel) frame_cnt <= frame_cnt - ONE;
      word_cnt <= wr_nxt - release_nxt;
      full_q   <= (wr_nxt - release_nxt) == FULL;
      // current commit_ptr only: words committed on this edge show up one edge later,
      // which keeps the head read clear of the word being written now
      head_vld <= ~rew & (commit_ptr != rd_nxt);
      head     <= mem[rd_nxt[FIFO_DEPTH-1:0]];
    end
  end

  assign fifo.full           = full_q;
  assign fifo.count          = word_cnt;
  assign fifo.frame_count    = frame_cnt;
  assign fifo.data_out       = head.data;
  assign fifo.data_out_start = head.sof;
  assign fifo.data_out_end   = head.eof;
  assign fifo.data_out_valid = head_vld;

`ifdef PACKET_FIFO_STATS_EN
  logic        drop;
  logic [15:0] drop_cnt;

  assign drop = (state == IN_FRAME && (fifo.data_in_abort ||
                 (fifo.data_in_enable && (fifo.data_in_start || used_full)))) ||
                (!fifo.data_in_abort && fifo.data_in_enable && fifo.data_in_start &&
                 state != IN_FRAME && used_full);

  always_ff @(posedge data_in_clock or posedge reset) begin
    if (reset)                          drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

  assign fifo.drop_count = drop_cnt;
`endif
endmodule

// File: tb/tb_packet_fifo.sv
// Randomised + directed bench for packet_fifo against a queue-level frame model.
module tb_packet_fifo;
  localparam int DW = 8, FD = 4, FULLN = 16;

  logic reset, clk;
  packet_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();
  packet_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .reset(reset), .data_in_clock(clk), .fifo(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          sof;
    logic          eof;
    logic [DW-1:0] d;
    int            stamp;
  } went_t;

  went_t mq[$];   // committed, not yet released (oldest first)
  went_t sq[$];   // staged frame
  int rd_off, fs_off, wmode, edge_n, drops;
  bit open, rew_last, v_pre, chk_en;
  int pass_n = 0, tot_n = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_clear();
    mq.delete(); sq.delete();
    rd_off = 0; fs_off = 0; wmode = 0; drops = 0; open = 0; rew_last = 0;
  endfunction

  function automatic void do_commit();
    foreach (sq[i]) begin went_t w = sq[i]; w.stamp = edge_n; mq.push_back(w); end
    sq.delete();
    wmode = 0;
  endfunction

  function automatic void model_step();
    int used; bit rw, pp; went_t h, w;
    edge_n++;
    used = sq.size() + mq.size();
    rw = bus.data_out_rewind && open;
    pp = bus.data_out_enable && v_pre && !rw && rd_off < mq.size();
    rew_last = rw;
    if (rw) rd_off = fs_off;
    if (pp) begin
      h = mq[rd_off];
      if (h.sof) begin fs_off = rd_off; open = 1; end
      if (h.eof) begin
        open = 0;
        for (int i = 0; i <= rd_off; i++) void'(mq.pop_front());
        rd_off = 0;
      end else rd_off++;
    end
    w = '{sof: bus.data_in_start, eof: bus.data_in_end, d: bus.data_in, stamp: 0};
    if (bus.data_in_abort) begin
      if (wmode == 1) drops++;
      sq.delete(); wmode = 0;
    end else if (bus.data_in_enable) begin
      if (bus.data_in_start) begin
        if (wmode == 1) begin drops++; sq.delete(); end
        if (wmode != 1 && used == FULLN) begin
          drops++; wmode = bus.data_in_end ? 0 : 2;
        end else begin
          sq.push_back(w);
          if (bus.data_in_end) do_commit(); else wmode = 1;
        end
      end else if (wmode == 1) begin
        if (used == FULLN) begin drops++; sq.delete(); wmode = 2; end
        else begin sq.push_back(w); if (bus.data_in_end) do_commit(); end
      end else if (wmode == 2 && bus.data_in_end) wmode = 0;
    end
  endfunction

  always @(posedge clk) if (!reset) model_step();

  task automatic compare();
    int ec, fc; bit has, may, must; went_t h;
    ec = sq.size() + mq.size();
    fc = 0;
    foreach (mq[i]) if (mq[i].eof) fc++;
    chk("count", bus.count, ec);
    chk("full", bus.full, ec == FULLN);
    chk("frame_count", bus.frame_count, fc);
    has = !rew_last && rd_off < mq.size();
    may = 0; must = 0;
    if (has) begin
      h = mq[rd_off];
      may  = h.stamp <= edge_n - 1;
      must = h.stamp <= edge_n - 2;
    end
    if (bus.data_out_valid) begin
      chk("valid_early", bus.data_out_valid, may);
      if (may) chk("head", {bus.data_out_start, bus.data_out_end, bus.data_out}, {h.sof, h.eof, h.d});
    end else chk("valid_late", bus.data_out_valid, must);
`ifdef PACKET_FIFO_STATS_EN
    chk("drop_count", bus.drop_count, drops);
`endif
  endtask

  always @(negedge clk) begin
    v_pre = bus.data_out_valid;
    if (chk_en) compare();
  end

  task automatic step(input bit en, st, ed, ab, input logic [DW-1:0] d, input bit pp, rw);
    bus.data_in_enable = en; bus.data_in_start = st; bus.data_in_end = ed;
    bus.data_in_abort = ab; bus.data_in = d;
    bus.data_out_enable = pp; bus.data_out_rewind = rw;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!bus.data_out_valid && k < 2) begin idle(1); k++; end
    chk(nm, bus.data_out_valid, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (bus.count != 0 && k < 64) begin step(0, 0, 0, 0, '0, 1, 0); k++; end
    chk("drain", bus.count, 0);
    chk("drain_frames", bus.frame_count, 0);
  endtask

  task automatic write_frame(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++)
      step(1, i == 0, i == n - 1, 0, base + DW'(i), 0, 0);
  endtask

  initial begin
    reset = 1; chk_en = 0; edge_n = 0;
    model_clear();
    bus.data_in = '0; bus.data_in_enable = 0; bus.data_in_start = 0; bus.data_in_end = 0;
    bus.data_in_abort = 0; bus.data_out_enable = 0; bus.data_out_rewind = 0;
    repeat (3) @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_valid", bus.data_out_valid, 0);
    reset = 0; chk_en = 1;
    idle(1);
    chk("idle_frames", bus.frame_count, 0);
    chk("idle_full", bus.full, 0);

    // 4-word frame, in-order pops
    write_frame(4, 8'h10);
    chk("f4_frames", bus.frame_count, 1);
    chk("f4_count", bus.count, 4);
    wait_valid("f4_valid");
    for (int i = 0; i < 4; i++) begin
      chk("f4_data", bus.data_out, 8'h10 + i);
      chk("f4_start", bus.data_out_start, i == 0);
      chk("f4_end", bus.data_out_end, i == 3);
      step(0, 0, 0, 0, '0, 1, 0);
    end
    chk("f4_count_after", bus.count, 0);
    chk("f4_frames_after", bus.frame_count, 0);

    // abort of a 3-word frame
    step(1, 1, 0, 0, 8'h21, 0, 0);
    step(1, 0, 0, 0, 8'h22, 0, 0);
    step(1, 0, 0, 0, 8'h23, 0, 0);
    chk("ab_count_pre", bus.count, 3);
    step(0, 0, 0, 1, '0, 0, 0);
    chk("ab_count", bus.count, 0);
    idle(2);
    chk("ab_valid", bus.data_out_valid, 0);
`ifdef PACKET_FIFO_STATS_EN
    chk("ab_drops", bus.drop_count, 1);
`endif

    // 20-word frame into a 16-entry buffer
    for (int i = 0; i < 20; i++) begin
      step(1, i == 0, i == 19, 0, DW'(8'h30 + i), 0, 0);
      if (i == 15) begin chk("ov_full", bus.full, 1); chk("ov_count16", bus.count, 16); end
      if (i == 16) begin chk("ov_discard", bus.count, 0); chk("ov_nfull", bus.full, 0); end
    end
    chk("ov_frames", bus.frame_count, 0);
    write_frame(2, 8'h40);
    chk("ov_next_count", bus.count, 2);
    chk("ov_next_frames", bus.frame_count, 1);
`ifdef PACKET_FIFO_STATS_EN
    chk("ov_drops", bus.drop_count, 2);
`endif
    wait_valid("ov_valid");
    chk("ov_next_data", bus.data_out, 8'h40);
    drain();

    // rewind after 3 of 5 words
    write_frame(5, 8'h50);
    wait_valid("rw_valid");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, '0, 1, 0);
    chk("rw_head3", bus.data_out, 8'h53);
    step(0, 0, 0, 0, '0, 1, 1);
    chk("rw_valid_low", bus.data_out_valid, 0);
    wait_valid("rw_valid_back");
    chk("rw_data0", bus.data_out, 8'h50);
    chk("rw_start0", bus.data_out_start, 1);
    chk("rw_count", bus.count, 5);
    drain();

    // single-word commit on the same edge as an end-word release
    write_frame(2, 8'h60);
    wait_valid("sw_valid");
    step(0, 0, 0, 0, '0, 1, 0);
    chk("sw_head_end", bus.data_out_end, 1);
    step(1, 1, 1, 0, 8'h70, 1, 0);
    chk("sw_frames", bus.frame_count, 1);
    chk("sw_count", bus.count, 1);
    wait_valid("sw_valid2");
    chk("sw_data", bus.data_out, 8'h70);
    drain();

    // reset with a frame half-popped and another half-written
    write_frame(3, 8'h80);
    wait_valid("rs_valid");
    step(1, 1, 0, 0, 8'h90, 1, 0);
    step(1, 0, 0, 0, 8'h91, 0, 0);
    chk_en = 0;
    bus.data_in_enable = 0; bus.data_in_start = 0; bus.data_in_end = 0;
    bus.data_out_enable = 0;
    reset = 1;
    model_clear();
    #1;
    chk("rs_count", bus.count, 0);
    chk("rs_frames", bus.frame_count, 0);
    chk("rs_valid0", bus.data_out_valid, 0);
    chk("rs_out", {bus.data_out_start, bus.data_out_end, bus.data_out}, 0);
    @(negedge clk);
    reset = 0; chk_en = 1;
    write_frame(2, 8'hA0);
    chk("rs_next_frames", bus.frame_count, 1);
    wait_valid("rs_next_valid");
    chk("rs_next_data", bus.data_out, 8'hA0);
    drain();

    // random traffic: slow reader first (overflow pressure), then fast reader
    for (int c = 0; c < 4000; c++) begin
      int pr = (c < 2000) ? 30 : 85;
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 3, DW'($urandom_range(0, 255)),
           $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 5);
    end
    idle(3);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
